seq_ctrl: RTL and testbench

Parametrised read → process → write sequencer for a single memory-to-memory pass. On `start` it issues a burst of `len` reads from `base_rd`, asserts the processing-element enable one cycle after each read (one-cycle memory latency), and issues the matching writes to `base_wr` after a configurable PE latency, then reports completion. It sits between the block RAMs and the PE datapath and generalises the fixed 16-word counter FSM with runtime base/length, variable PE latency, busy/done handshake and optional stall.

---
 rtl/seq_ctrl_pkg.sv | 18 +
 rtl/seq_ctrl_pipe.sv | 65 ++++++
 rtl/seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared state encoding and latency constants for the
// read -> process -> write sequencer.
package seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Block RAM read latency: the PE sees data one cycle after en_rd.
  localparam int RD_LAT = 1;

  // Deepest PE latency the write pipe is expected to cover.
  localparam int PE_LAT_MAX = 8;

endpackage

// File: rtl/seq_ctrl_pipe.sv
// seq_ctrl_pipe: valid + index shift register carrying read tokens to the
// write side. DEPTH is the total delay from in_valid to last_valid. The
// final stage exists only as the registered last_* outputs, so during a
// hold the visible enables read 0 while the stored tokens stay put and
// nothing is shown twice once shifting resumes.
module seq_ctrl_pipe
  import seq_ctrl_pkg::*;
#(
  parameter int DEPTH = RD_LAT + 1,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             first_valid,
  output logic             last_valid,
  output logic [WIDTH-1:0] last_data,
  output logic             pending
);

  localparam int NS = DEPTH - 1;

  logic [NS-1:0]    stage_valid;
  logic [WIDTH-1:0] stage_data [NS];

  // Any token still stored means writes are outstanding beyond this cycle.
  assign pending = |stage_valid;

  // Stored stages: cleared on reset/flush, frozen on hold, otherwise shift.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      stage_valid <= '0;
      for (int k = 0; k < NS; k++) begin
        stage_data[k] <= '0;
      end
    end else if (!hold) begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= in_data;
      for (int k = 1; k < NS; k++) begin
        stage_valid[k] <= stage_valid[k-1];
        stage_data[k]  <= stage_data[k-1];
      end
    end
  end

  // Registered taps: first stage drives en_pe, final stage drives en_wr.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      first_valid <= 1'b0;
      last_valid  <= 1'b0;
      last_data   <= '0;
    end else if (hold) begin
      first_valid <= 1'b0;
      last_valid  <= 1'b0;
    end else begin
      first_valid <= in_valid;
      last_valid  <= stage_valid[NS-1];
      last_data   <= stage_data[NS-1];
    end
  end

endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: sequencer for one memory-to-memory pass. Issues len reads from
// base_rd, enables the PE one cycle later and the matching writes to base_wr
// PE_LAT cycles after that, then pulses done.
// Optional feature: define SEQ_CTRL_STALL_EN to add the stall input, which
// freezes the sequence and blanks the enables while high.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_rd,
  input  logic [ADDR_W-1:0] base_wr,
  input  logic [ADDR_W:0]   len,
`ifdef SEQ_CTRL_STALL_EN
  input  logic              stall,
`endif
  output logic              en_rd,
  output logic [ADDR_W-1:0] addr_rd,
  output logic              en_pe,
  output logic              en_wr,
  output logic [ADDR_W-1:0] addr_wr,
  output logic              busy,
  output logic              done
);

  localparam int PIPE_DEPTH = RD_LAT + PE_LAT;

  state_t            state, state_next;
  logic [ADDR_W:0]   cnt, cnt_next, len_q, len_n;
  logic [ADDR_W-1:0] base_rd_q, base_rd_n, base_wr_q, base_wr_n;
  logic [ADDR_W-1:0] addr_rd_n, wr_addr_cur;
  logic              hold, stall_w, pending, en_rd_n, rd_active;

`ifdef SEQ_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // The read being shown this cycle becomes a pipe token on the next shift.
  assign rd_active   = (state == RUN);
  assign wr_addr_cur = base_wr_q + cnt[ADDR_W-1:0];

  // Next-state, read index and captured-parameter logic; clr overrides all.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    len_n      = len_q;
    base_rd_n  = base_rd_q;
    base_wr_n  = base_wr_q;
    hold       = stall_w && ((state == RUN) || (state == DRAIN));
    case (state)
      IDLE: begin
        if (start) begin
          len_n      = len;
          base_rd_n  = base_rd;
          base_wr_n  = base_wr;
          cnt_next   = '0;
          state_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          if (cnt == len_q - 1'b1) begin
            state_next = DRAIN;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (!hold && !pending) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (clr) begin
      state_next = IDLE;
      cnt_next   = '0;
      len_n      = len_q;
      base_rd_n  = base_rd_q;
      base_wr_n  = base_wr_q;
    end
    en_rd_n   = (state_next == RUN) && !hold;
    addr_rd_n = base_rd_n + cnt_next[ADDR_W-1:0];
  end

  // State register plus registered read-side, busy and done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      base_rd_q <= '0;
      base_wr_q <= '0;
      en_rd     <= 1'b0;
      addr_rd   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      len_q     <= len_n;
      base_rd_q <= base_rd_n;
      base_wr_q <= base_wr_n;
      en_rd     <= en_rd_n;
      if (en_rd_n) begin
        addr_rd <= addr_rd_n;
      end
      busy <= (state_next == RUN) || (state_next == DRAIN);
      done <= (state_next == DONE);
    end
  end

  seq_ctrl_pipe #(
    .DEPTH(PIPE_DEPTH),
    .WIDTH(ADDR_W)
  ) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .flush      (clr),
    .hold       (hold),
    .in_valid   (rd_active),
    .in_data    (wr_addr_cur),
    .first_valid(en_pe),
    .last_valid (en_wr),
    .last_data  (addr_wr),
    .pending    (pending)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed bench for seq_ctrl. Two instances share the inputs,
// one with PE_LAT=1 and one with PE_LAT=3. A vector table covers short
// sequences cycle by cycle; longer passes are compared against a cycle
// formula. The stall sequence is built only when SEQ_CTRL_STALL_EN is defined.
module tb_seq_ctrl;

  typedef struct packed {
    logic       en_rd;
    logic [3:0] addr_rd;
    logic       en_pe;
    logic       en_wr;
    logic [3:0] addr_wr;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    logic       start;
    logic       clr;
    logic [3:0] base_rd;
    logic [3:0] base_wr;
    logic [4:0] len;
    obs_t       exp;
  } vec_t;

  localparam int NV = 18;

  logic       clk, rst, clr, start;
  logic [3:0] base_rd, base_wr;
  logic [4:0] len;
`ifdef SEQ_CTRL_STALL_EN
  logic       stall;
`endif

  logic       en_rd1, en_pe1, en_wr1, busy1, done1;
  logic [3:0] addr_rd1, addr_wr1;
  logic       en_rd3, en_pe3, en_wr3, busy3, done3;
  logic [3:0] addr_rd3, addr_wr3;
  obs_t       obs1, obs3;

  int errors = 0;
  int checks = 0;
  vec_t vecs [NV];

  assign obs1 = {en_rd1, addr_rd1, en_pe1, en_wr1, addr_wr1, busy1, done1};
  assign obs3 = {en_rd3, addr_rd3, en_pe3, en_wr3, addr_wr3, busy3, done3};

  seq_ctrl #(.ADDR_W(4), .PE_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .base_rd(base_rd), .base_wr(base_wr), .len(len),
`ifdef SEQ_CTRL_STALL_EN
    .stall(stall),
`endif
    .en_rd(en_rd1), .addr_rd(addr_rd1), .en_pe(en_pe1), .en_wr(en_wr1),
    .addr_wr(addr_wr1), .busy(busy1), .done(done1)
  );

  seq_ctrl #(.ADDR_W(4), .PE_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .start(start),
    .base_rd(base_rd), .base_wr(base_wr), .len(len),
`ifdef SEQ_CTRL_STALL_EN
    .stall(stall),
`endif
    .en_rd(en_rd3), .addr_rd(addr_rd3), .en_pe(en_pe3), .en_wr(en_wr3),
    .addr_wr(addr_wr3), .busy(busy3), .done(done3)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs in cycle t of a pass, t=1 being the first read cycle.
  function automatic obs_t model(int t, logic [3:0] brd, logic [3:0] bwr, int n, int lat);
    obs_t e;
    e = '0;
    if (t >= 1 && t <= n) begin
      e.en_rd   = 1'b1;
      e.addr_rd = 4'(int'(brd) + t - 1);
    end
    if (t >= 2 && t <= n + 1) e.en_pe = 1'b1;
    if (t >= 2 + lat && t <= n + 1 + lat) begin
      e.en_wr   = 1'b1;
      e.addr_wr = 4'(int'(bwr) + t - 2 - lat);
    end
    if (t >= 1 && t <= n + 1 + lat) e.busy = 1'b1;
    if (t == n + 2 + lat) e.done = 1'b1;
    return e;
  endfunction

  function automatic vec_t mk(logic s, logic c, logic [3:0] br, logic [3:0] bw, logic [4:0] n,
                              logic er, logic [3:0] ar, logic ep, logic ew, logic [3:0] aw,
                              logic b, logic d);
    vec_t v;
    v.start = s;
    v.clr = c;
    v.base_rd = br;
    v.base_wr = bw;
    v.len = n;
    v.exp = {er, ar, ep, ew, aw, b, d};
    return v;
  endfunction

  // Drive one cycle of inputs, let the edge pass, sample point is #1 later.
  task automatic applyStimulus(logic s, logic c, logic [3:0] br, logic [3:0] bw, logic [4:0] n);
    start   = s;
    clr     = c;
    base_rd = br;
    base_wr = bw;
    len     = n;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag, obs_t exp, obs_t act, logic care_rd, logic care_wr);
    obs_t e, a;
    e = exp;
    a = act;
    if (!care_rd) begin
      e.addr_rd = '0;
      a.addr_rd = '0;
    end
    if (!care_wr) begin
      e.addr_wr = '0;
      a.addr_wr = '0;
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got rd=%b/%0d pe=%b wr=%b/%0d busy=%b done=%b, expected rd=%b/%0d pe=%b wr=%b/%0d busy=%b done=%b",
               tag, a.en_rd, a.addr_rd, a.en_pe, a.en_wr, a.addr_wr, a.busy, a.done,
               e.en_rd, e.addr_rd, e.en_pe, e.en_wr, e.addr_wr, e.busy, e.done);
    end
  endtask

  task automatic idleCycles(int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 5'd0);
  endtask

  // One full pass checked cycle by cycle on the chosen instance.
  task automatic runPass(string tag, logic [3:0] brd, logic [3:0] bwr, int n, bit sel3);
    int lat;
    obs_t act;
    lat = sel3 ? 3 : 1;
    applyStimulus(1'b1, 1'b0, brd, bwr, 5'(n));
    for (int t = 1; t <= n + 3 + lat; t++) begin
      act = sel3 ? obs3 : obs1;
      checkOutput($sformatf("%s t=%0d", tag, t), model(t, brd, bwr, n, lat), act,
                  model(t, brd, bwr, n, lat).en_rd, model(t, brd, bwr, n, lat).en_wr);
      if (t < n + 3 + lat) applyStimulus(1'b0, 1'b0, brd, bwr, 5'(n));
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    start = 1'b0;
    base_rd = '0;
    base_wr = '0;
    len = '0;
`ifdef SEQ_CTRL_STALL_EN
    stall = 1'b0;
`endif

    vecs[0]  = mk(1, 0, 5, 9, 3,    1, 5, 0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 5, 9, 3,    1, 6, 1, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 5, 9, 3,    1, 7, 1, 1, 9, 1, 0);
    vecs[3]  = mk(0, 0, 5, 9, 3,    0, 0, 1, 1, 10, 1, 0);
    vecs[4]  = mk(0, 0, 5, 9, 3,    0, 0, 0, 1, 11, 1, 0);
    vecs[5]  = mk(0, 0, 5, 9, 3,    0, 0, 0, 0, 0, 0, 1);
    vecs[6]  = mk(1, 0, 2, 2, 1,    0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 2, 2, 1,    0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 4, 4, 0,    0, 0, 0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 0, 4, 4, 0,    0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 1, 1, 1, 5,    0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 1, 5,    0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 0, 12, 0, 2,   1, 12, 0, 0, 0, 1, 0);
    vecs[13] = mk(1, 0, 3, 3, 5,    1, 13, 1, 0, 0, 1, 0);
    vecs[14] = mk(1, 0, 3, 3, 5,    0, 0, 1, 1, 0, 1, 0);
    vecs[15] = mk(1, 0, 3, 3, 5,    0, 0, 0, 1, 1, 1, 0);
    vecs[16] = mk(0, 0, 3, 3, 5,    0, 0, 0, 0, 0, 0, 1);
    vecs[17] = mk(0, 0, 3, 3, 5,    0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pe1", '0, obs1, 1'b1, 1'b1);
    checkOutput("reset pe3", '0, obs3, 1'b1, 1'b1);
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].start, vecs[i].clr, vecs[i].base_rd, vecs[i].base_wr, vecs[i].len);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp, obs1, vecs[i].exp.en_rd, vecs[i].exp.en_wr);
    end
    idleCycles(8);

    $display("[TB] full memory pass");
    runPass("full16", 4'd0, 4'd0, 16, 1'b0);
    idleCycles(4);

    $display("[TB] wrapping pass, PE_LAT=3");
    runPass("wrap", 4'd14, 4'd3, 4, 1'b1);
    idleCycles(4);

    $display("[TB] clr on fifth read");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 5'd16);
    for (int t = 1; t <= 5; t++) begin
      checkOutput($sformatf("preclr t=%0d", t), model(t, 4'd0, 4'd0, 16, 1), obs1, 1'b1,
                  model(t, 4'd0, 4'd0, 16, 1).en_wr);
      if (t < 5) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 5'd16);
    end
    applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 5'd16);
    checkOutput("clr next", '0, obs1, 1'b0, 1'b0);
    checkOutput("clr next pe3", '0, obs3, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 5'd16);
      checkOutput($sformatf("after clr %0d", k), '0, obs1, 1'b0, 1'b0);
    end
    runPass("restart", 4'd0, 4'd0, 16, 1'b0);
    idleCycles(4);

`ifdef SEQ_CTRL_STALL_EN
    $display("[TB] stall for three cycles");
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 5'd8);
    for (int t = 1; t <= 15; t++) begin
      obs_t e;
      if (t >= 3 && t <= 5) begin
        e = '0;
        e.addr_rd = 4'd1;
        e.busy = 1'b1;
        checkOutput($sformatf("stall t=%0d", t), e, obs1, 1'b1, 1'b0);
      end else begin
        e = model((t <= 2) ? t : t - 3, 4'd0, 4'd0, 8, 1);
        checkOutput($sformatf("stall t=%0d", t), e, obs1, e.en_rd, e.en_wr);
      end
      stall = (t >= 2 && t <= 4);
      if (t < 15) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 5'd8);
    end
    stall = 1'b0;
    idleCycles(4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
